collision_detector: RTL and testbench
=====================================

// Module: collision_detector
// PURPOSE
//  Produces the 5-bit collision vector that monsters, player and missile blocks consume.
//  Inputs are per-pixel drawing requests from every on-screen object.
//  Detects pixel overlap between object pairs.
//  Emits a one-clock collision pulse per pair, at most once per frame.
//  Latches a per-frame summary and keeps saturating hit counters for score/lives logic.
// PARAMETERS
//  COUNT_WIDTH    8  width of each per-channel hit counter (saturating)
//  ONE_PER_FRAME  1  1: at most one pulse per channel per frame; 0: pulse on every overlapping pixel
// PORTS
//  clk              in   1  system clock
//  resetN           in   1  synchronous reset, active-high (1 = reset)
//  startOfFrame     in   1  one-clk pulse at frame start
//  enable           in   1  0 masks all detection (pause/game over); counters hold
//  playerDR         in   1  player ship pixel
//  playerMissleDR   in   1  player missile pixel
//  monsterDR        in   1  monster pixel
//  monsterMissleDR  in   1  monster missile pixel
//  borderDR         in   1  screen border pixel
//  collision        out  5  one-clk pulses, bit map below
//  frameSummary     out  5  channels that fired during previous frame
//  hitCount         out  5*COUNT_WIDTH  packed counters, channel i at [i*W +: W]
// BEHAVIOUR
//  Channel map (raw overlap o[i], combinational AND of DRs):
//   0 player & monster
//   1 playerMissle & monster
//   2 monsterMissle & border
//   3 playerMissle & border
//   4 monsterMissle & player
//  Reset (resetN=1 at a clk edge): collision=0, frameSummary=0, per-frame flags=0, all hitCount=0.
//  Pulse generation, per channel i:
//   - Latency 1: overlap sampled at edge t gives collision[i]=1 during cycle t+1.
//   - Condition: enable & o[i] & (~flag[i] | ONE_PER_FRAME==0).
//   - flag[i] sets on the pulse and stays set until the next startOfFrame.
//  startOfFrame edge:
//   - frameSummary <= flag (the frame just ended); flag <= 0.
//   - An overlap in the same cycle belongs to the NEW frame: it pulses and sets flag. It is not in frameSummary.
//  Overlap spanning many pixels or lines (ONE_PER_FRAME=1): exactly one pulse, at the first pixel.
//  Several channels overlapping in one cycle: all pulse together, independently.
//  hitCount[i] increments on each collision[i] pulse and saturates at 2^W-1 (no wrap).
//  enable=0:
//   - No pulses, flags unchanged, counters hold.
//   - startOfFrame still rolls frameSummary and clears flags.
//  Reset asserted mid-frame: next cycle all outputs 0. First startOfFrame after reset gives frameSummary=0.
//  No combinational path from inputs to outputs; all outputs registered.
// STRUCTURE
//  collision_pkg:
//   - localparams COL_PLAYER_MONSTER=0, COL_PMISSILE_MONSTER=1, COL_MMISSILE_BORDER=2,
//     COL_PMISSILE_BORDER=3, COL_MMISSILE_PLAYER=4.
//   - NUM_COLLISIONS=5.
//   - typedef logic [NUM_COLLISIONS-1:0] collision_t.
//  Sub-module collision_channel (one channel): raw overlap in; flag, pulse, summary bit and
//  saturating counter; instantiated NUM_COLLISIONS times via generate.
//  Top level: overlap AND-terms and output packing only.
// TESTING
//  1 Reset: hold resetN=1 for 2 clk with all DR=1 -> collision=0, frameSummary=0, hitCount all 0.
//  2 Single hit: playerMissleDR=monsterDR=1 for pixels t..t+31 over 3 lines ->
//    collision=5'b00010 only in cycle t+1, hitCount[1]=1; next startOfFrame -> frameSummary=5'b00010.
//  3 Same-cycle SOF: startOfFrame=1 with monsterMissleDR=borderDR=1 ->
//    collision[2] pulses next cycle; frameSummary[2]=0; following SOF -> frameSummary[2]=1.
//  4 Multi-channel: playerDR=monsterDR=monsterMissleDR=1 in one cycle ->
//    collision=5'b10001 for exactly one cycle; hitCount[0]=hitCount[4]=1.
//  5 Saturation: COUNT_WIDTH=2, channel 3 hit in 5 consecutive frames -> hitCount[3] reads 1,2,3,3,3.
//  6 Enable/reset: enable=0 during overlap -> no pulse, counters hold.
//    resetN=1 mid-frame after a hit -> frameSummary=0 at next SOF; ONE_PER_FRAME=0 -> one pulse per overlapping pixel.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared channel indices and types for the collision detector.
// Channel order matches the bit order of the collision vector.
package collision_pkg;

    localparam int COL_PLAYER_MONSTER   = 0;
    localparam int COL_PMISSILE_MONSTER = 1;
    localparam int COL_MMISSILE_BORDER  = 2;
    localparam int COL_PMISSILE_BORDER  = 3;
    localparam int COL_MMISSILE_PLAYER  = 4;

    localparam int NUM_COLLISIONS = 5;

    typedef logic [NUM_COLLISIONS-1:0] collision_t;

endpackage

// File: rtl/collision_channel.sv
// One collision channel: per-frame flag, registered pulse,
// last-frame summary bit and a saturating hit counter.
module collision_channel #(
    parameter int COUNT_WIDTH   = 8,
    parameter bit ONE_PER_FRAME = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   enable,
    input  logic                   overlap,
    output logic                   pulse,
    output logic                   summary,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic flag;
    logic fire;
    logic flagNext;

    // A start-of-frame overlap belongs to the new frame, so the old flag
    // must not suppress it.
    always_comb begin
        fire = enable & overlap
             & (startOfFrame | ~flag | ~ONE_PER_FRAME);
        flagNext = startOfFrame ? fire : (flag | fire);
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            flag    <= 1'b0;
            pulse   <= 1'b0;
            summary <= 1'b0;
            count   <= '0;
        end else begin
            flag  <= flagNext;
            pulse <= fire;
            if (startOfFrame) begin
                summary <= flag;
            end
            if (fire && count != COUNT_MAX) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/collision_detector.sv
// Pixel-overlap collision detector: forms the pairwise overlap terms
// and hands each to its own collision channel.
module collision_detector
    import collision_pkg::*;
#(
    parameter int COUNT_WIDTH   = 8,
    parameter bit ONE_PER_FRAME = 1'b1
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                startOfFrame,
    input  logic                                enable,
    input  logic                                playerDR,
    input  logic                                playerMissleDR,
    input  logic                                monsterDR,
    input  logic                                monsterMissleDR,
    input  logic                                borderDR,
    output logic [NUM_COLLISIONS-1:0]           collision,
    output logic [NUM_COLLISIONS-1:0]           frameSummary,
    output logic [NUM_COLLISIONS*COUNT_WIDTH-1:0] hitCount
);

    collision_t overlap;

    always_comb begin
        overlap = '0;
        overlap[COL_PLAYER_MONSTER]   = playerDR & monsterDR;
        overlap[COL_PMISSILE_MONSTER] = playerMissleDR & monsterDR;
        overlap[COL_MMISSILE_BORDER]  = monsterMissleDR & borderDR;
        overlap[COL_PMISSILE_BORDER]  = playerMissleDR & borderDR;
        overlap[COL_MMISSILE_PLAYER]  = monsterMissleDR & playerDR;
    end

    for (genvar i = 0; i < NUM_COLLISIONS; i++) begin : gChannel
        collision_channel #(
            .COUNT_WIDTH  (COUNT_WIDTH),
            .ONE_PER_FRAME(ONE_PER_FRAME)
        ) uChannel (
            .clk         (clk),
            .resetN      (resetN),
            .startOfFrame(startOfFrame),
            .enable      (enable),
            .overlap     (overlap[i]),
            .pulse       (collision[i]),
            .summary     (frameSummary[i]),
            .count       (hitCount[i*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_collision_detector.sv
// Randomized bench for collision_detector: three configurations driven in
// parallel and compared every cycle against a behavioural frame model.
module tb_collision_detector;
    import collision_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetN, startOfFrame, enable;
    logic playerDR, playerMissleDR, monsterDR, monsterMissleDR, borderDR;

    logic [4:0]  colA, sumA, colB, sumB, colC, sumC;
    logic [39:0] hitA, hitC;
    logic [9:0]  hitB;

    collision_detector #(.COUNT_WIDTH(8), .ONE_PER_FRAME(1'b1)) dutA (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .enable(enable), .playerDR(playerDR),
        .playerMissleDR(playerMissleDR), .monsterDR(monsterDR),
        .monsterMissleDR(monsterMissleDR), .borderDR(borderDR),
        .collision(colA), .frameSummary(sumA), .hitCount(hitA));

    collision_detector #(.COUNT_WIDTH(2), .ONE_PER_FRAME(1'b1)) dutB (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .enable(enable), .playerDR(playerDR),
        .playerMissleDR(playerMissleDR), .monsterDR(monsterDR),
        .monsterMissleDR(monsterMissleDR), .borderDR(borderDR),
        .collision(colB), .frameSummary(sumB), .hitCount(hitB));

    collision_detector #(.COUNT_WIDTH(8), .ONE_PER_FRAME(1'b0)) dutC (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .enable(enable), .playerDR(playerDR),
        .playerMissleDR(playerMissleDR), .monsterDR(monsterDR),
        .monsterMissleDR(monsterMissleDR), .borderDR(borderDR),
        .collision(colC), .frameSummary(sumC), .hitCount(hitC));

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [39:0] got,
                            input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Model state per configuration: A (W=8, one/frame), B (W=2), C (every pixel)
    bit mFlag [3][5];
    bit mCol  [3][5];
    bit mSum  [3][5];
    int mCnt  [3][5];
    int mMax  [3] = '{255, 3, 255};
    bit mOpf  [3] = '{1'b1, 1'b1, 1'b0};
    int mWidth[3] = '{8, 2, 8};

    task automatic modelEdge(input bit rst, input bit sof, input bit en,
                             input bit o[5]);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                bit seen, fire;
                if (rst) begin
                    mFlag[k][i] = 0; mCol[k][i] = 0;
                    mSum[k][i] = 0;  mCnt[k][i] = 0;
                end else begin
                    seen = sof ? 1'b0 : mFlag[k][i];
                    fire = en && o[i] && (!seen || !mOpf[k]);
                    if (sof) mSum[k][i] = mFlag[k][i];
                    mFlag[k][i] = seen || fire;
                    mCol[k][i] = fire;
                    if (fire && mCnt[k][i] < mMax[k]) mCnt[k][i]++;
                end
            end
        end
    endtask

    task automatic compareAll();
        for (int k = 0; k < 3; k++) begin
            logic [39:0] eCol, eSum, eHit, gCol, gSum, gHit;
            eCol = '0; eSum = '0; eHit = '0;
            for (int i = 0; i < 5; i++) begin
                eCol[i] = mCol[k][i];
                eSum[i] = mSum[k][i];
                eHit |= 40'(mCnt[k][i]) << (i * mWidth[k]);
            end
            case (k)
                0: begin gCol = 40'(colA); gSum = 40'(sumA); gHit = hitA; end
                1: begin gCol = 40'(colB); gSum = 40'(sumB); gHit = 40'(hitB); end
                default: begin gCol = 40'(colC); gSum = 40'(sumC); gHit = hitC; end
            endcase
            checkVal($sformatf("collision[cfg%0d]", k), gCol, eCol);
            checkVal($sformatf("frameSummary[cfg%0d]", k), gSum, eSum);
            checkVal($sformatf("hitCount[cfg%0d]", k), gHit, eHit);
        end
    endtask

    // One clock: model follows the inputs present at the edge, then compare.
    task automatic step();
        bit o[5];
        bit rst, sof, en;
        o[COL_PLAYER_MONSTER]   = playerDR & monsterDR;
        o[COL_PMISSILE_MONSTER] = playerMissleDR & monsterDR;
        o[COL_MMISSILE_BORDER]  = monsterMissleDR & borderDR;
        o[COL_PMISSILE_BORDER]  = playerMissleDR & borderDR;
        o[COL_MMISSILE_PLAYER]  = monsterMissleDR & playerDR;
        rst = resetN; sof = startOfFrame; en = enable;
        @(posedge clk);
        modelEdge(rst, sof, en, o);
        #1;
        compareAll();
    endtask

    task automatic setDR(input bit p, input bit pm, input bit m,
                         input bit mm, input bit b);
        playerDR = p; playerMissleDR = pm; monsterDR = m;
        monsterMissleDR = mm; borderDR = b;
    endtask

    task automatic idle(input int n);
        setDR(0, 0, 0, 0, 0);
        startOfFrame = 0;
        repeat (n) step();
    endtask

    task automatic frameStart();
        setDR(0, 0, 0, 0, 0);
        startOfFrame = 1;
        step();
        startOfFrame = 0;
    endtask

    initial begin
        resetN = 1; startOfFrame = 0; enable = 1;
        setDR(1, 1, 1, 1, 1);
        repeat (2) step();
        checkVal("resetCollision", 40'(colA), 40'd0);
        checkVal("resetHitCount", hitA, 40'd0);
        resetN = 0;
        idle(3);

        // Single hit spanning 3 lines of 32 pixels
        frameStart();
        idle(2);
        for (int line = 0; line < 3; line++) begin
            setDR(0, 1, 1, 0, 0);
            for (int px = 0; px < 32; px++) begin
                step();
                if (line == 0 && px == 0)
                    checkVal("singleHitPulse", 40'(colA), 40'h02);
            end
            idle(8);
        end
        frameStart();
        checkVal("singleHitSummary", 40'(sumA), 40'h02);

        // Overlap in the same cycle as start of frame
        idle(4);
        setDR(0, 0, 0, 1, 1);
        startOfFrame = 1;
        step();
        idle(3);
        frameStart();

        // Several channels at once
        idle(2);
        setDR(1, 0, 1, 1, 0);
        step();
        checkVal("multiChannel", 40'(colA), 40'h11);
        idle(2);

        // Channel 3 in five consecutive frames, saturating the narrow counter
        for (int f = 0; f < 5; f++) begin
            frameStart();
            setDR(0, 1, 0, 0, 1);
            repeat (3) step();
            idle(2);
        end

        // Enable low during overlap, then start of frame while disabled
        frameStart();
        enable = 0;
        setDR(1, 1, 1, 1, 1);
        repeat (4) step();
        startOfFrame = 1;
        step();
        startOfFrame = 0;
        repeat (3) step();
        enable = 1;
        idle(2);

        // Reset mid-frame after a hit
        frameStart();
        setDR(1, 0, 1, 0, 0);
        repeat (3) step();
        resetN = 1;
        step();
        resetN = 0;
        idle(2);
        frameStart();
        checkVal("resetSummary", 40'(sumA), 40'h00);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            playerDR        = ($urandom_range(0, 3) == 0);
            playerMissleDR  = ($urandom_range(0, 3) == 0);
            monsterDR       = ($urandom_range(0, 2) == 0);
            monsterMissleDR = ($urandom_range(0, 3) == 0);
            borderDR        = ($urandom_range(0, 2) == 0);
            startOfFrame    = ($urandom_range(0, 39) == 0);
            enable          = ($urandom_range(0, 9) != 0);
            resetN          = ($urandom_range(0, 499) == 0);
            step();
        end
        resetN = 0; enable = 1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
